// File: rtl/main.def.v
// rtl/main.def.v - global datapath width shared by execute-stage blocks
`ifndef LEN_DATA
`define LEN_DATA 32
`endif

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - three-requester arbiter feeding one shared prefix adder with issue/result stages
// Optional ADDER_ARB_FIXED_PRIO_EN: fixed priority id0 > id1 > id2 instead of round-robin.
`include "main.def.v"

module adder_arbiter (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [2:0]             req_valid,
  output logic [2:0]             req_ready,
  input  logic [3*`LEN_DATA-1:0] req_a,
  input  logic [3*`LEN_DATA-1:0] req_b,
  input  logic [2:0]             req_sub,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [1:0]             res_id,
  output logic [`LEN_DATA-1:0]   res_sum,
  output logic                   res_cout
);
  localparam int W   = `LEN_DATA;
  localparam int LVL = (W > 1) ? $clog2(W) : 1;

  logic         r_s1_valid;
  logic [1:0]   r_s1_id;
  logic [W-1:0] r_s1_a;
  logic [W-1:0] r_s1_b;
  logic         r_s1_cin;

  logic         r_res_valid;
  logic [1:0]   r_res_id;
  logic [W-1:0] r_res_sum;
  logic         r_res_cout;

  logic         w_s2_load;
  logic         w_s1_load;
  logic [2:0]   w_grant;
  logic         w_accept;
  logic [1:0]   w_acc_id;
  logic [W-1:0] w_sel_a;
  logic [W-1:0] w_sel_b;
  logic         w_sel_sub;

  logic [W-1:0] w_p;
  logic [W-1:0] w_g;
  logic [W-1:0] w_pg_p;
  logic [W-1:0] w_pg_g;
  logic [W-1:0] w_sum;
  logic         w_cout;

  // S1 may take a new grant whenever S2 drains or S1 is empty; otherwise we are stalled
  assign w_s2_load = ~r_res_valid | res_ready;
  assign w_s1_load = w_s2_load | ~r_s1_valid;
  assign req_ready = w_grant & {3{w_s1_load & rst_n}};
  assign w_accept  = |req_ready;
  assign w_acc_id  = w_grant[1] ? 2'd1 : (w_grant[2] ? 2'd2 : 2'd0);

`ifdef ADDER_ARB_FIXED_PRIO_EN
  always_comb begin
    w_grant = 3'b000;
    if (req_valid[0])      w_grant = 3'b001;
    else if (req_valid[1]) w_grant = 3'b010;
    else if (req_valid[2]) w_grant = 3'b100;
  end
`else
  logic [1:0] r_rr_ptr;

  always_comb begin
    w_grant = 3'b000;
    case (r_rr_ptr)
      2'd1: begin
        if (req_valid[1])      w_grant = 3'b010;
        else if (req_valid[2]) w_grant = 3'b100;
        else if (req_valid[0]) w_grant = 3'b001;
      end
      2'd2: begin
        if (req_valid[2])      w_grant = 3'b100;
        else if (req_valid[0]) w_grant = 3'b001;
        else if (req_valid[1]) w_grant = 3'b010;
      end
      default: begin
        if (req_valid[0])      w_grant = 3'b001;
        else if (req_valid[1]) w_grant = 3'b010;
        else if (req_valid[2]) w_grant = 3'b100;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= 2'd0;
    end else if (w_accept) begin
      r_rr_ptr <= (w_acc_id == 2'd2) ? 2'd0 : w_acc_id + 2'd1;
    end
  end
`endif

  always_comb begin
    w_sel_a   = req_a[W-1:0];
    w_sel_b   = req_b[W-1:0];
    w_sel_sub = req_sub[0];
    case (w_acc_id)
      2'd1: begin
        w_sel_a   = req_a[2*W-1:W];
        w_sel_b   = req_b[2*W-1:W];
        w_sel_sub = req_sub[1];
      end
      2'd2: begin
        w_sel_a   = req_a[3*W-1:2*W];
        w_sel_b   = req_b[3*W-1:2*W];
        w_sel_sub = req_sub[2];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_id    <= 2'd0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_cin   <= 1'b0;
    end else if (w_s1_load) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_id  <= w_acc_id;
        r_s1_a   <= w_sel_a;
        r_s1_b   <= w_sel_sub ? ~w_sel_b : w_sel_b;
        r_s1_cin <= w_sel_sub;
      end
    end
  end

  // Kogge-Stone prefix; high-to-low in-place update reads the previous level at i-d
  always_comb begin
    w_p    = r_s1_a ^ r_s1_b;
    w_g    = (r_s1_a & r_s1_b) | {{(W-1){1'b0}}, w_p[0] & r_s1_cin};
    w_pg_p = w_p;
    w_pg_g = w_g;
    for (int l = 0; l < LVL; l++) begin
      for (int i = W - 1; i >= (1 << l); i--) begin
        w_pg_g[i] = w_pg_g[i] | (w_pg_p[i] & w_pg_g[i - (1 << l)]);
        w_pg_p[i] = w_pg_p[i] & w_pg_p[i - (1 << l)];
      end
    end
    w_sum  = w_p ^ {w_pg_g[W-2:0], r_s1_cin};
    w_cout = w_pg_g[W-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_id    <= 2'd0;
      r_res_sum   <= '0;
      r_res_cout  <= 1'b0;
    end else if (w_s2_load) begin
      r_res_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_res_id   <= r_s1_id;
        r_res_sum  <= w_sum;
        r_res_cout <= w_cout;
      end
    end
  end

  assign res_valid = r_res_valid;
  assign res_id    = r_res_id;
  assign res_sum   = r_res_sum;
  assign res_cout  = r_res_cout;

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - scoreboard bench for adder_arbiter (LEN_DATA = 32)
module tb_adder_arbiter;
  localparam int W = 32;

  typedef struct packed {
    logic [1:0]   id;
    logic [W-1:0] sum;
    logic         cout;
  } res_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [2:0]     req_valid;
  logic [2:0]     req_ready;
  logic [3*W-1:0] req_a;
  logic [3*W-1:0] req_b;
  logic [2:0]     req_sub;
  logic           res_valid;
  logic           res_ready;
  logic [1:0]     res_id;
  logic [W-1:0]   res_sum;
  logic           res_cout;

  always #5 clk = ~clk;

  adder_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_sum   (res_sum),
    .res_cout  (res_cout)
  );

  res_t         sb[$];
  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] ra[3];
  logic [W-1:0] rb[3];
  logic [2:0]   rv;
  logic [2:0]   rs;
  bit           refill;
  int           acc;
  int           n_acc = 0;
  int           n_res = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [1:0] id, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic sub);
    logic [W:0] t;
    res_t r;
    t = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{W{1'b0}}, sub};
    r.id   = id;
    r.sum  = t[W-1:0];
    r.cout = t[W];
    return r;
  endfunction

  task automatic drive();
    req_valid = rv;
    req_sub   = rs;
    for (int i = 0; i < 3; i++) begin
      req_a[i*W +: W] = ra[i];
      req_b[i*W +: W] = rb[i];
    end
  endtask

  task automatic new_op(input int i);
    ra[i] = $urandom;
    rb[i] = $urandom;
    rs[i] = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 7))
      0: ra[i] = 32'hFFFF_FFFF;
      1: rb[i] = 32'h0000_0001;
      2: ra[i] = 32'h0;
      3: rb[i] = ra[i];
      default: ;
    endcase
  endtask

  // One clock: handshakes are observed at the falling edge, requester state updates after the rising edge
  task automatic cycle();
    res_t e;
    drive();
    @(negedge clk);
    acc = -1;
    check("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
    if (res_valid) check("res_has_owner", 64'(sb.size() != 0), 64'd1);
    if (res_valid && res_ready && sb.size() != 0) begin
      e = sb.pop_front();
      n_res++;
      check("res_id", 64'(res_id), 64'(e.id));
      check("res_sum", 64'(res_sum), 64'(e.sum));
      check("res_cout", 64'(res_cout), 64'(e.cout));
    end
    for (int i = 0; i < 3; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        acc = i;
        n_acc++;
        sb.push_back(model(2'(i), ra[i], rb[i], rs[i]));
      end
    end
    @(posedge clk);
    #1;
    if (acc >= 0) begin
      if (refill) new_op(acc);
      else rv[acc] = 1'b0;
    end
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_res_valid"}, 64'(res_valid), 64'd0);
    check({tag, "_res_id"}, 64'(res_id), 64'd0);
    check({tag, "_res_sum"}, 64'(res_sum), 64'd0);
    check({tag, "_res_cout"}, 64'(res_cout), 64'd0);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
  endtask

  task automatic issue_one(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    int got;
    ra[id] = a;
    rb[id] = b;
    rs[id] = sub;
    rv[id] = 1'b1;
    got = -1;
    for (int k = 0; k < 10 && got != id; k++) begin
      cycle();
      got = acc;
    end
    check("issue_accept", 64'(got), 64'(id));
  endtask

  initial begin
    logic [W-1:0] saved;
    int           cnt;
    int           res0;
    int           acc0;

    rv = 3'b111;
    rs = 3'b000;
    refill = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ra[i] = '0;
      rb[i] = '0;
    end
    drive();
    #1;
    reset_checks("rst0");
    repeat (2) @(posedge clk);
    #1;
    reset_checks("rst1");
    rv = 3'b000;
    drive();
    rst_n = 1'b1;

    // single add with latency check
    ra[0] = 32'h5; rb[0] = 32'h3; rs[0] = 1'b0; rv = 3'b001;
    cycle();
    check("t1_acc", 64'(acc), 64'd0);
    check("t1_lat1", 64'(res_valid), 64'd0);
    cycle();
    check("t1_lat2", 64'(res_valid), 64'd1);
    check("t1_id", 64'(res_id), 64'd0);
    check("t1_sum", 64'(res_sum), 64'h8);
    check("t1_cout", 64'(res_cout), 64'd0);
    cycle();
    check("t1_empty", 64'(sb.size()), 64'd0);

    // carry / borrow corners
    issue_one(1, 32'hFFFF_FFFF, 32'h1, 1'b0);
    repeat (2) cycle();
    check("c1_sum", 64'(res_sum), 64'h0);
    check("c1_cout", 64'(res_cout), 64'd1);
    issue_one(2, 32'h0, 32'h1, 1'b1);
    repeat (2) cycle();
    check("c2_sum", 64'(res_sum), 64'hFFFF_FFFF);
    check("c2_cout", 64'(res_cout), 64'd0);
    issue_one(0, 32'h8000_0000, 32'h8000_0000, 1'b1);
    repeat (2) cycle();
    check("c3_sum", 64'(res_sum), 64'h0);
    check("c3_cout", 64'(res_cout), 64'd1);
    repeat (2) cycle();
    check("corner_empty", 64'(sb.size()), 64'd0);

    // reset while S1 and S2 both hold work
    res_ready = 1'b0;
    refill = 1'b1;
    new_op(1);
    rv = 3'b010;
    cycle();
    cycle();
    check("mid_full", 64'(res_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    reset_checks("mid_rst");
    sb.delete();
    rv = 3'b000;
    refill = 1'b0;
    drive();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    res_ready = 1'b1;
    repeat (4) cycle();
    check("mid_no_stale", 64'(res_valid), 64'd0);

    // contention from freshly reset pointer
    refill = 1'b1;
    for (int i = 0; i < 3; i++) new_op(i);
    rv = 3'b111;
    for (int k = 0; k < 6; k++) begin
      cycle();
`ifdef ADDER_ARB_FIXED_PRIO_EN
      check("grant_order", 64'(acc), 64'd0);
`else
      check("grant_order", 64'(acc), 64'(k % 3));
`endif
    end
    rv = 3'b000;
    refill = 1'b0;
    repeat (4) cycle();
    check("cont_empty", 64'(sb.size()), 64'd0);

    // backpressure: four requests, consumer stalled for three cycles
    res0 = n_res;
    res_ready = 1'b0;
    refill = 1'b1;
    new_op(0);
    rv = 3'b001;
    cycle();
    cycle();
    check("bp_valid", 64'(res_valid), 64'd1);
    saved = res_sum;
    cycle();
    check("bp_stall_acc", 64'(acc), -64'sd1);
    check("bp_ready0", 64'(req_ready), 64'd0);
    check("bp_hold_valid", 64'(res_valid), 64'd1);
    check("bp_hold_sum", 64'(res_sum), 64'(saved));
    res_ready = 1'b1;
    cnt = 2;
    for (int k = 0; k < 10 && cnt < 4; k++) begin
      refill = (cnt < 3);
      cycle();
      if (k == 0) check("bp_resume_acc", 64'(acc), 64'd0);
      if (acc >= 0) cnt++;
    end
    refill = 1'b0;
    repeat (4) cycle();
    check("bp_count", 64'(n_res - res0), 64'd4);
    check("bp_empty", 64'(sb.size()), 64'd0);

    // random traffic
    res0 = n_res;
    acc0 = n_acc;
    refill = 1'b0;
    for (int k = 0; k < 10000; k++) begin
      for (int i = 0; i < 3; i++) begin
        if (!rv[i] && $urandom_range(0, 1) == 1) begin
          new_op(i);
          rv[i] = 1'b1;
        end
      end
      res_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    res_ready = 1'b1;
    for (int k = 0; k < 20 && (rv != 3'b000 || sb.size() != 0); k++) cycle();
    check("rand_drained", 64'(sb.size()), 64'd0);
    check("rand_count", 64'(n_res - res0), 64'(n_acc - acc0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
